// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared state type, width helpers and
// address field extraction for the dm_cache_rd block.
package dm_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MREQ,
    S_REFILL,
    S_RESP
  } dmc_state_t;

  function automatic int boff_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int woff_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int addr_w,
    input int data_w,
    input int sets,
    input int words
  );
    return addr_w - idx_w(sets) - woff_w(words)
         - boff_w(data_w);
  endfunction

  // Fields are returned zero-extended to 64 bits;
  // callers slice down to the field width.
  function automatic logic [63:0] field(
    input logic [63:0] a,
    input int          lsb,
    input int          w
  );
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return (a >> lsb) & m;
  endfunction

  function automatic logic [63:0] get_tag(
    input logic [63:0] a,
    input int          boff,
    input int          woff,
    input int          idxw,
    input int          tagw
  );
    return field(a, boff + woff + idxw, tagw);
  endfunction

  function automatic logic [63:0] get_idx(
    input logic [63:0] a,
    input int          boff,
    input int          woff,
    input int          idxw
  );
    return field(a, boff + woff, idxw);
  endfunction

  function automatic logic [63:0] get_woff(
    input logic [63:0] a,
    input int          boff,
    input int          woff
  );
    return field(a, boff, woff);
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// dm_cache_array: tag/valid/data storage with a per-word
// write port and a registered read of one whole line.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 24,
  localparam int IDX_W  = idx_w(SETS),
  localparam int WOFF_W = woff_w(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_line [WORDS],
  input  logic              inv,
  input  logic              we,
  input  logic              fill,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS][WORDS];

  // Valid bits: cleared on reset, dropped when a refill
  // starts, set once the last word of the line lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv) begin
      valid[wr_idx] <= 1'b0;
    end else if (fill) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data RAM; contents are qualified by valid,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      data[wr_idx][wr_word] <= wr_data;
    end
    if (fill) begin
      tags[wr_idx] <= wr_tag;
    end
  end

  // Registered read of the addressed line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      rd_line  <= '{default: '0};
    end else begin
      rd_valid <= valid[rd_idx];
      rd_tag   <= tags[rd_idx];
      rd_line  <= data[rd_idx];
    end
  end

endmodule

// File: rtl/dm_cache_rd.sv
// dm_cache_rd: read-only direct-mapped cache controller.
// DM_CACHE_STATS_EN enables hit/miss counters.
module dm_cache_rd
  import dm_cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int BOFF_W = boff_w(DATA_W);
  localparam int WOFF_W = woff_w(WORDS_PER_LINE);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  =
    tag_w(ADDR_W, DATA_W, SETS, WORDS_PER_LINE);
  localparam int LOW_W  = WOFF_W + BOFF_W;
  localparam logic [WOFF_W-1:0] LAST = '1;

  dmc_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [WOFF_W-1:0] cnt;

  logic [63:0] f_ridx, f_idx, f_tag, f_woff;
  logic [IDX_W-1:0]  req_idx, lat_idx, rd_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic [WOFF_W-1:0] lat_woff;
  logic              unused_hi;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_line [WORDS_PER_LINE];
  logic              hit, inv, we, fill;

  assign f_ridx = get_idx(64'(req_addr),
                          BOFF_W, WOFF_W, IDX_W);
  assign f_idx  = get_idx(64'(addr_q),
                          BOFF_W, WOFF_W, IDX_W);
  assign f_tag  = get_tag(64'(addr_q),
                          BOFF_W, WOFF_W, IDX_W, TAG_W);
  assign f_woff = get_woff(64'(addr_q),
                           BOFF_W, WOFF_W);

  assign req_idx  = f_ridx[IDX_W-1:0];
  assign lat_idx  = f_idx[IDX_W-1:0];
  assign lat_tag  = f_tag[TAG_W-1:0];
  assign lat_woff = f_woff[WOFF_W-1:0];
  assign unused_hi = ^{f_ridx[63:IDX_W],
                       f_idx[63:IDX_W],
                       f_tag[63:TAG_W],
                       f_woff[63:WOFF_W]};

  // In IDLE the array reads the incoming index so the
  // line is ready for the tag compare in LOOKUP.
  assign rd_idx = (state == S_IDLE) ? req_idx : lat_idx;

  assign hit  = rd_valid && (rd_tag == lat_tag);
  assign inv  = (state == S_LOOKUP) && !hit;
  assign we   = (state == S_REFILL) && mem_rsp_valid;
  assign fill = we && (cnt == LAST);

  assign req_ready     = (state == S_IDLE);
  assign rsp_valid     = (state == S_RESP);
  assign mem_req_valid = (state == S_MREQ);

  dm_cache_array #(
    .DATA_W (DATA_W),
    .SETS   (SETS),
    .WORDS  (WORDS_PER_LINE),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .inv      (inv),
    .we       (we),
    .fill     (fill),
    .wr_idx   (lat_idx),
    .wr_word  (cnt),
    .wr_data  (mem_rsp_data),
    .wr_tag   (lat_tag)
  );

  // Controller FSM with address latch, beat counter
  // and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      cnt          <= '0;
      mem_req_addr <= '0;
      rsp_hit      <= 1'b0;
      rsp_data     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            rsp_hit  <= 1'b1;
            rsp_data <= rd_line[lat_woff];
            state    <= S_RESP;
          end else begin
            mem_req_addr <= {lat_tag, lat_idx,
                             {LOW_W{1'b0}}};
            state        <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_rsp_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == lat_woff) begin
              rsp_data <= mem_rsp_data;
            end
            if (cnt == LAST) begin
              rsp_hit <= 1'b0;
              state   <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  // Saturating hit/miss counters, stepped once per
  // response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_RESP) begin
      if (rsp_hit) begin
        if (hit_count != 32'hFFFF_FFFF) begin
          hit_count <= hit_count + 32'd1;
        end
      end else begin
        if (miss_count != 32'hFFFF_FFFF) begin
          miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
